// File: rtl/pixel_loader.sv
// pixel_loader
// Packs a received byte stream (one colour byte per data_ready strobe) into
// RGB pixels and spreads them across `channels` panel RAMs, each
// width*scan pixels deep. Signals frame completion, supports a restart, and
// optionally double-buffers against the matrix driver's frame start.
//
// Build option: define PIXEL_LOADER_DBUF_EN for double buffering. That adds
// the PENDING state, the wr_buf/disp_buf swap on frame_start and the overrun
// flag. Without it, wr_buf/disp_buf/overrun are tied 0 and frame_start is
// ignored.
//
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   data, data_ready received byte and its one-cycle strobe
//   restart          abandon current frame; next byte is pixel 0 colour 0 ch 0
//   frame_start      start-of-display-frame pulse from the matrix driver
//   wr_addr          RAM write address
//   wr_data          data replicated `colors` times
//   wr_byte_en       one-hot colour lane
//   wr_en            one-hot channel write enable
//   wr_buf/disp_buf  buffer half being written / to be displayed
//   frame_done       one-cycle pulse alongside the final write of a frame
//   overrun          sticky: a byte arrived while waiting for a swap
module pixel_loader #(
    parameter int width      = 64,
    parameter int scan_bit   = 4,
    parameter int channels   = 2,
    parameter int colors     = 3,
    parameter int color_bits = 8,
    localparam int length     = width * (1 << scan_bit),
    localparam int length_bit = $clog2(length),
    localparam int ch_bit     = (channels > 1) ? $clog2(channels) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [color_bits-1:0]        data,
    input  logic                         data_ready,
    input  logic                         restart,
    input  logic                         frame_start,
    output logic [length_bit-1:0]        wr_addr,
    output logic [colors*color_bits-1:0] wr_data,
    output logic [colors-1:0]            wr_byte_en,
    output logic [channels-1:0]          wr_en,
    output logic                         wr_buf,
    output logic                         disp_buf,
    output logic                         frame_done,
    output logic                         overrun
);

    localparam logic [length_bit-1:0] LAST_ADDR = length_bit'(length - 1);
    localparam logic [ch_bit-1:0]     LAST_CH   = ch_bit'(channels - 1);

`ifdef PIXEL_LOADER_DBUF_EN
    typedef enum logic {LOAD, PENDING} state_t;
`else
    typedef enum logic {LOAD} state_t;
`endif

    state_t state, state_d;

    logic [colors-1:0]     lane;
    logic [length_bit-1:0] addr;
    logic [ch_bit-1:0]     chan;

    logic accept;
    logic last_byte;
    logic complete;

    // Wraps use compares so non-power-of-two channels/colors work.
    assign last_byte = lane[colors-1] && (addr == LAST_ADDR) && (chan == LAST_CH);
    assign complete  = accept && last_byte;

`ifdef PIXEL_LOADER_DBUF_EN
    logic drop;
    logic swap;
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
`ifdef PIXEL_LOADER_DBUF_EN
        drop    = 1'b0;
        swap    = 1'b0;
        if (restart) begin
            state_d = LOAD;
        end else if (state == PENDING) begin
            drop = data_ready;
            if (frame_start) begin
                swap    = 1'b1;
                state_d = LOAD;
            end
        end else begin
            accept = data_ready;
            // A frame_start in this same cycle is deliberately not honoured;
            // the swap waits for the next one.
            if (data_ready && last_byte) state_d = PENDING;
        end
`else
        if (restart) state_d = LOAD;
        else         accept  = data_ready && (state == LOAD);
`endif
    end

    // Write port and pixel counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane       <= colors'(1);
            addr       <= '0;
            chan       <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_byte_en <= '0;
            wr_en      <= '0;
            frame_done <= 1'b0;
        end else begin
            wr_byte_en <= '0;
            wr_en      <= '0;
            frame_done <= complete;
            if (restart) begin
                // restart beats a coincident data_ready: the byte is discarded
                lane <= colors'(1);
                addr <= '0;
                chan <= '0;
            end else if (accept) begin
                wr_addr    <= addr;
                wr_data    <= {colors{data}};
                wr_byte_en <= lane;
                wr_en      <= channels'(1) << chan;
                if (lane[colors-1]) begin
                    lane <= colors'(1);
                    if (addr == LAST_ADDR) begin
                        addr <= '0;
                        chan <= (chan == LAST_CH) ? '0 : chan + 1'b1;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end else begin
                    lane <= lane << 1;
                end
            end
        end
    end

`ifdef PIXEL_LOADER_DBUF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_buf   <= 1'b1;
            disp_buf <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (restart)   overrun <= 1'b0;
            else if (drop) overrun <= 1'b1;
            if (swap) begin
                disp_buf <= wr_buf;
                wr_buf   <= ~wr_buf;
            end
        end
    end
`else
    assign wr_buf   = 1'b0;
    assign disp_buf = 1'b0;
    assign overrun  = 1'b0;
`endif

endmodule
